// File: rtl/fp_mult_param.sv
// fp_mult_param: multi-cycle IEEE-754 multiplier with parametrised widths and round-to-nearest-even.
// Define FPMUL_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module fp_mult_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [EXP_W+MAN_W:0]   A,
    input  logic [EXP_W+MAN_W:0]   B,
    input  logic                   En,
    output logic [EXP_W+MAN_W:0]   Result,
    output logic                   Ready,
    output logic                   Busy,
    output logic                   NaN,
    output logic                   Overflow,
    output logic                   Underflow,
    output logic                   Inexact
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;
    localparam int P  = 2 * M;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE  = XW'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CHECK, MULT, MULT_WAIT, NORM, ROUND, DONE} state_t;
    state_t state_q, state_d;

    logic [W-1:0]           a_q, b_q;
    logic [M-1:0]           mul_a, mul_b;
    logic [P-1:0]           prod_mul;
    logic [P-1:0]           prod_q;
    logic                   sign_q;
    logic signed [XW-1:0]   exp_q;
    logic                   sticky_q;
    logic [W-1:0]           res_q;
    logic                   nan_q, ovf_q, unf_q, inx_q;

    // Returns {rounded mantissa with carry, inexact}.
    function automatic logic [M+1:0] round_rne(input logic [M-1:0] mant, input logic guard,
                                               input logic sticky);
        logic       up;
        logic [M:0] sum;
        up  = guard & (sticky | mant[0]);
        sum = {1'b0, mant} + {{M{1'b0}}, up};
        return {sum, guard | sticky};
    endfunction

    logic                 a_s, b_s, sgn;
    logic [EXP_W-1:0]     a_e, b_e;
    logic [MAN_W-1:0]     a_f, b_f;
    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [XW-1:0] a_ex, b_ex;

    assign a_s = a_q[W-1];
    assign b_s = b_q[W-1];
    assign sgn = a_s ^ b_s;
    assign a_e = a_q[W-2 -: EXP_W];
    assign b_e = b_q[W-2 -: EXP_W];
    assign a_f = a_q[MAN_W-1:0];
    assign b_f = b_q[MAN_W-1:0];
    assign a_nan = (&a_e) & (|a_f);
    assign b_nan = (&b_e) & (|b_f);
    assign a_inf = (&a_e) & ~(|a_f);
    assign b_inf = (&b_e) & ~(|b_f);
`ifdef FPMUL_SUBNORMAL_EN
    assign a_zero = ~(|a_e) & ~(|a_f);
    assign b_zero = ~(|b_e) & ~(|b_f);
`else
    assign a_zero = ~(|a_e);
    assign b_zero = ~(|b_e);
`endif
    // Subnormal encodings carry exponent 1 with hidden bit 0.
    assign a_ex = (|a_e) ? $signed({2'b00, a_e}) : ONE;
    assign b_ex = (|b_e) ? $signed({2'b00, b_e}) : ONE;

    logic         chk_special, chk_nan;
    logic [W-1:0] chk_res;

    always_comb begin
        chk_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        chk_nan     = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        if (chk_nan)
            chk_res = QNAN;
        else if (a_inf | b_inf)
            chk_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            chk_res = {sgn, {(W-1){1'b0}}};
    end

    logic [P-1:0]         norm_prod;
    logic signed [XW-1:0] norm_exp;
    logic                 norm_sticky, norm_stay;

    always_comb begin
        norm_prod   = prod_q;
        norm_exp    = exp_q;
        norm_sticky = sticky_q;
        norm_stay   = 1'b0;
        if (prod_q[P-1]) begin
            norm_prod   = prod_q >> 1;
            norm_sticky = sticky_q | prod_q[0];
            norm_exp    = exp_q + ONE;
`ifdef FPMUL_SUBNORMAL_EN
            norm_stay   = 1'b1;
        end else if (exp_q < ONE) begin
            // Denormalise toward exponent 1, keeping shifted-out bits in sticky.
            norm_prod   = prod_q >> 1;
            norm_sticky = sticky_q | prod_q[0];
            norm_exp    = exp_q + ONE;
            norm_stay   = 1'b1;
        end else if (!prod_q[P-2] && (exp_q > ONE)) begin
            norm_prod   = prod_q << 1;
            norm_exp    = exp_q - ONE;
            norm_stay   = 1'b1;
`endif
        end
    end

    logic [M+1:0]         rnd;
    logic [M-1:0]         mant_r;
    logic signed [XW-1:0] exp_r;
    logic [EXP_W-1:0]     e_fld;
    logic [W-1:0]         rnd_res;
    logic                 rnd_ovf, rnd_unf, rnd_inx;
`ifdef FPMUL_SUBNORMAL_EN
    logic                 tiny;
    assign tiny = (exp_q == ONE) && !prod_q[P-2];
`endif

    always_comb begin
        rnd     = round_rne(prod_q[P-2 -: M], prod_q[M-2], sticky_q | (|prod_q[M-3:0]));
        mant_r  = rnd[M+1] ? rnd[M+1:2] : rnd[M:1];
        exp_r   = rnd[M+1] ? exp_q + ONE : exp_q;
        e_fld   = mant_r[M-1] ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}};
        rnd_res = {sign_q, e_fld, mant_r[MAN_W-1:0]};
        rnd_ovf = 1'b0;
        rnd_unf = 1'b0;
        rnd_inx = rnd[0];
        if (exp_r >= EMAX) begin
            rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_ovf = 1'b1;
            rnd_inx = 1'b1;
        end
`ifdef FPMUL_SUBNORMAL_EN
        else begin
            rnd_unf = tiny & rnd[0];
        end
`else
        else if (exp_r < ONE) begin
            rnd_res = {sign_q, {(W-1){1'b0}}};
            rnd_unf = 1'b1;
            rnd_inx = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (En) state_d = CHECK;
            CHECK:     state_d = chk_special ? DONE : MULT;
            MULT:      state_d = MULT_WAIT;
            MULT_WAIT: state_d = NORM;
            NORM:      state_d = norm_stay ? NORM : ROUND;
            ROUND:     state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Control and architectural outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            Result    <= '0;
            Ready     <= 1'b0;
            Busy      <= 1'b0;
            NaN       <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            Inexact   <= 1'b0;
        end else begin
            state_q <= state_d;
            Ready   <= 1'b0;
            case (state_q)
                IDLE: begin
                    Busy <= En;
                    if (En) begin
                        NaN       <= 1'b0;
                        Overflow  <= 1'b0;
                        Underflow <= 1'b0;
                        Inexact   <= 1'b0;
                    end
                end
                DONE: begin
                    Result    <= res_q;
                    NaN       <= nan_q;
                    Overflow  <= ovf_q;
                    Underflow <= unf_q;
                    Inexact   <= inx_q;
                    Ready     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Multiplier register, left without reset for DSP mapping
    always_ff @(posedge clk) begin
        prod_mul <= P'(mul_a) * P'(mul_b);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: if (En) begin
                a_q   <= A;
                b_q   <= B;
                mul_a <= {|A[W-2 -: EXP_W], A[MAN_W-1:0]};
                mul_b <= {|B[W-2 -: EXP_W], B[MAN_W-1:0]};
            end
            CHECK: begin
                sign_q <= sgn;
                res_q  <= chk_res;
                nan_q  <= chk_nan;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
                inx_q  <= 1'b0;
            end
            MULT:      exp_q <= a_ex + b_ex - BIAS;
            MULT_WAIT: begin
                prod_q   <= prod_mul;
                sticky_q <= 1'b0;
            end
            NORM: begin
                prod_q   <= norm_prod;
                exp_q    <= norm_exp;
                sticky_q <= norm_sticky;
            end
            ROUND: begin
                res_q <= rnd_res;
                ovf_q <= rnd_ovf;
                unf_q <= rnd_unf;
                inx_q <= rnd_inx;
            end
            default: ;
        endcase
    end
endmodule
